// File: rtl/trail_ram_arbiter.sv
// trail_ram_arbiter: round-robin trail RAM write arbiter for two players with a full-RAM clear sweep.
// The clear engine is built only when TRAIL_ARB_CLEAR_EN is defined.
module trail_ram_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8,
  parameter int NUM_PIXELS = 307200,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = 8'h00
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              clear_start,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  input  logic              req2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] data2,
  output logic              gnt2,
  output logic              wren,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] data,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              conflict
);
  logic last, go, clr_wr;
  logic [ADDR_W-1:0] clr_addr;
`ifdef TRAIL_ARB_CLEAR_EN
  localparam logic CLEAR = 1'b0, ARB = 1'b1;
  logic state, sweep_end;
  assign go = state == ARB && !clear_start;
  assign clr_wr = state == CLEAR && !sweep_end;
  // sweep_end marks the idle cycle after the last clear write, before grants resume
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state <= CLEAR;
      clr_addr <= '0;
      sweep_end <= 1'b0;
      clear_busy <= 1'b1;
      clear_done <= 1'b0;
    end else begin
      clear_busy <= clr_wr;
      clear_done <= state == CLEAR && sweep_end;
      if (state == ARB) begin
        if (clear_start) begin
          state <= CLEAR;
          clr_addr <= '0;
        end
      end else if (sweep_end) begin
        state <= ARB;
        sweep_end <= 1'b0;
      end else begin
        sweep_end <= clr_addr == ADDR_W'(NUM_PIXELS - 1);
        clr_addr <= clr_addr == ADDR_W'(NUM_PIXELS - 1) ? clr_addr : clr_addr + 1'b1;
      end
    end
`else
  logic unused_cfg;
  assign unused_cfg = clear_start ^ NUM_PIXELS[0];
  assign go = 1'b1;
  assign clr_wr = 1'b0;
  assign clr_addr = '0;
  assign clear_busy = 1'b0;
  assign clear_done = 1'b0;
`endif
  // last = 1 means player 2 was served most recently
  assign gnt1 = go && req1 && (!req2 || last);
  assign gnt2 = go && req2 && (!req1 || !last);
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      last <= 1'b1;
      wren <= 1'b0;
      wraddress <= '0;
      data <= '0;
      conflict <= 1'b0;
    end else begin
      if (gnt1 || gnt2) last <= gnt2;
      wren <= clr_wr || gnt1 || gnt2;
      wraddress <= clr_wr ? clr_addr : gnt1 ? addr1 : addr2;
      data <= clr_wr ? CLEAR_VALUE : gnt1 ? data1 : data2;
      conflict <= go && req1 && req2 && addr1 == addr2;
    end
endmodule
